pipe_control_unit: RTL and testbench
====================================

Name: pipe_control_unit

Overview:
- Parametrised successor to the single-cycle control decoder.
- Decodes the 7-bit opcode plus funct7 into a full control bundle: ALUOp, ALUSrc, RegWrite, MemRead, MemWrite, MemtoReg, Branch, Mul.
- Registers the bundle into the ID/EX stage, so the block sits between IF/ID and EX.
- Generates the pipeline stall for load-use hazards and for multi-cycle multiply, and supports flush.

Parameters:
- ALUOP_W, 2, width of ALUOp_o.
- REG_AW, 5, register-address width.
- MUL_LAT, 3, EX cycles occupied by a multiply. Legal range 1..15.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  synchronous active-low reset.
- valid_i  in  1  IF/ID holds a real instruction.
- Op_i  in  7  opcode field [6:0].
- Funct7_i  in  7  funct7 field.
- RS1_i  in  REG_AW  source register 1.
- RS2_i  in  REG_AW  source register 2.
- ex_mem_read_i  in  1  instruction currently in EX is a load.
- ex_rd_i  in  REG_AW  destination register of the EX instruction.
- flush_i  in  1  squash the decode-stage instruction (branch taken).
- ALUOp_o  out  ALUOP_W  registered; equals Op_i[6:5] zero-extended.
- ALUSrc_o  out  1  registered; 1 = immediate operand.
- RegWrite_o  out  1  registered.
- MemRead_o  out  1  registered.
- MemWrite_o  out  1  registered.
- MemtoReg_o  out  1  registered.
- Branch_o  out  1  registered.
- Mul_o  out  1  registered; EX performs a multiply.
- valid_o  out  1  registered; ID/EX holds a real instruction.
- stall_o  out  1  combinational; hold PC and IF/ID this cycle.
- illegal_o  out  1  registered; see Optional Feature.

Behaviour:
- Decode table (RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, Branch):
  - R-type 0110011 -> 1,0,0,0,0,0
  - I-ALU 0010011 -> 1,1,0,0,0,0
  - load 0000011 -> 1,1,1,0,1,0
  - store 0100011 -> 0,1,0,1,0,0
  - branch 1100011 -> 0,0,0,0,0,1
  - any other opcode -> unsupported; treated as a bubble.
- Mul decode: Mul = R-type && Funct7_i == 7'b0000001.
- Bubble: every registered output 0, including valid_o.
- Reset: rst_n_i low at an edge forces a bubble, FSM to IDLE, counter to 0, illegal_o to 0. stall_o = 0 while rst_n_i is low.
- Latency: one cycle from decode inputs to registered outputs.
- Load-use hazard (hz), combinational: valid_i && ex_mem_read_i && ex_rd_i != 0 && (ex_rd_i == RS1_i || (uses_rs2 && ex_rd_i == RS2_i)). uses_rs2 is true for R-type, store and branch.
- FSM states: IDLE and MUL_WAIT; 4-bit down-counter cnt.
- Register update priority in IDLE: reset > flush_i > hz > normal decode.
  - flush_i: load a bubble; stall_o = 0.
  - hz: load a bubble; stall_o = 1.
  - Normal: load the decoded bundle, valid_o = valid_i. If valid_i is 0, load a bubble.
  - Accepted Mul with MUL_LAT > 1: cnt <= MUL_LAT-1, go to MUL_WAIT. With MUL_LAT == 1 the FSM stays in IDLE.
- MUL_WAIT:
  - stall_o = 1; bubble loaded each cycle; cnt decrements.
  - When cnt == 1 at an edge, go to IDLE; stall_o is 0 in the following cycle.
  - Total stall cycles = MUL_LAT-1.
- flush_i in MUL_WAIT: bubble, cnt <= 0, go to IDLE immediately. stall_o = 0 in that cycle.
- Simultaneous flush_i and hz: flush wins; stall_o = 0.
- In IDLE, stall_o = hz && !flush_i.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN
- Defined:
  - illegal_o is set one cycle after valid_i && !flush_i && !stall_o with an unsupported opcode, with a bubble loaded in that cycle.
  - illegal_o is sticky until reset.
  - While illegal_o = 1, every decode is forced to a bubble (pipeline frozen for a trap).
- Undefined: illegal_o is tied to 0 and unsupported opcodes are silently bubbled.

Test Plan:
- Reset then Op_i=0110011, valid_i=1 -> next cycle ALUOp_o=01, RegWrite_o=1, ALUSrc_o=0, valid_o=1, stall_o=0.
- Op_i=0000011 -> next cycle ALUOp_o=00, ALUSrc_o=1, MemRead_o=1, MemtoReg_o=1, RegWrite_o=1.
- ex_mem_read_i=1, ex_rd_i=5, R-type with RS2_i=5 -> stall_o=1 that cycle and a bubble next cycle. Repeat with ex_rd_i=0 -> no stall.
- MUL_LAT=3, R-type with Funct7_i=0000001 -> Mul_o=1 next cycle, then stall_o=1 for exactly 2 cycles, then 0.
- Assert flush_i in the first MUL_WAIT cycle -> bubble, stall_o=0 that cycle, FSM back in IDLE.
- With CTRL_ILLEGAL_TRAP_EN, Op_i=1111111, valid_i=1 -> illegal_o=1 next cycle and stays 1; a following R-type produces valid_o=0. After rst_n_i=0 for one edge, illegal_o=0.

Source files
------------

// File: rtl/pipe_control_unit.sv
// ID/EX control decoder with load-use and multi-cycle multiply stall generation.
// Optional illegal-opcode trap: define CTRL_ILLEGAL_TRAP_EN.
module pipe_control_unit #(
  parameter int ALUOP_W = 2,
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 3
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               valid_i,
  input  logic [6:0]         Op_i,
  input  logic [6:0]         Funct7_i,
  input  logic [REG_AW-1:0]  RS1_i,
  input  logic [REG_AW-1:0]  RS2_i,
  input  logic               ex_mem_read_i,
  input  logic [REG_AW-1:0]  ex_rd_i,
  input  logic               flush_i,
  output logic [ALUOP_W-1:0] ALUOp_o,
  output logic               ALUSrc_o,
  output logic               RegWrite_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic               MemtoReg_o,
  output logic               Branch_o,
  output logic               Mul_o,
  output logic               valid_o,
  output logic               stall_o,
  output logic               illegal_o
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam bit         MUL_MULTI = (MUL_LAT > 1);

  typedef enum logic {IDLE, MUL_WAIT} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       accept;
  logic       trap;

  // Stage p0: combinational decode of the IF/ID instruction
  logic is_r_p0, is_i_p0, is_ld_p0, is_st_p0, is_br_p0;
  logic supported_p0, uses_rs2_p0, is_mul_p0, hz_p0;

  assign is_r_p0      = (Op_i == OP_R);
  assign is_i_p0      = (Op_i == OP_IALU);
  assign is_ld_p0     = (Op_i == OP_LD);
  assign is_st_p0     = (Op_i == OP_ST);
  assign is_br_p0     = (Op_i == OP_BR);
  assign supported_p0 = is_r_p0 | is_i_p0 | is_ld_p0 | is_st_p0 | is_br_p0;
  assign uses_rs2_p0  = is_r_p0 | is_st_p0 | is_br_p0;
  assign is_mul_p0    = is_r_p0 && (Funct7_i == 7'b0000001);
  assign hz_p0        = valid_i && ex_mem_read_i && (ex_rd_i != '0) &&
                        ((ex_rd_i == RS1_i) || (uses_rs2_p0 && (ex_rd_i == RS2_i)));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept && is_mul_p0 && MUL_MULTI) begin
          state_nxt = MUL_WAIT;
          cnt_nxt   = 4'(MUL_LAT - 1);
        end
      end
      MUL_WAIT: begin
        if (flush_i) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Flush beats a hazard; a trapped pipeline never accepts a new bundle.
  always_comb begin
    stall_o = 1'b0;
    accept  = 1'b0;
    if (rst_n_i) begin
      case (state)
        IDLE: begin
          stall_o = hz_p0 && !flush_i;
          accept  = valid_i && !flush_i && !hz_p0 && supported_p0 && !trap;
        end
        MUL_WAIT: stall_o = !flush_i;
        default: ;
      endcase
    end
  end

  // Stage p1: ID/EX control register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || !accept) begin
      ALUOp_o    <= '0;
      ALUSrc_o   <= 1'b0;
      RegWrite_o <= 1'b0;
      MemRead_o  <= 1'b0;
      MemWrite_o <= 1'b0;
      MemtoReg_o <= 1'b0;
      Branch_o   <= 1'b0;
      Mul_o      <= 1'b0;
      valid_o    <= 1'b0;
    end else begin
      ALUOp_o    <= ALUOP_W'(Op_i[6:5]);
      ALUSrc_o   <= is_i_p0 | is_ld_p0 | is_st_p0;
      RegWrite_o <= is_r_p0 | is_i_p0 | is_ld_p0;
      MemRead_o  <= is_ld_p0;
      MemWrite_o <= is_st_p0;
      MemtoReg_o <= is_ld_p0;
      Branch_o   <= is_br_p0;
      Mul_o      <= is_mul_p0;
      valid_o    <= 1'b1;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic trap_p1;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      trap_p1 <= 1'b0;
    end else if (valid_i && !flush_i && !stall_o && !supported_p0) begin
      trap_p1 <= 1'b1;
    end
  end

  assign trap      = trap_p1;
  assign illegal_o = trap_p1;
`else
  assign trap      = 1'b0;
  assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_control_unit.sv
// Scoreboard bench for pipe_control_unit: independent control model, directed plus random stimulus.
module tb_pipe_control_unit;
  localparam int ALUOP_W = 2;
  localparam int REG_AW  = 5;
  localparam int MUL_LAT = 3;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] IA = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] XX = 7'b1111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, valid, ex_mem_read, flush;
  logic [6:0]         op, funct7;
  logic [REG_AW-1:0]  rs1, rs2, ex_rd;
  logic [ALUOP_W-1:0] alu_op;
  logic alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch, mul;
  logic valid_out, stall, illegal;

  pipe_control_unit #(.ALUOP_W(ALUOP_W), .REG_AW(REG_AW), .MUL_LAT(MUL_LAT)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .Op_i(op), .Funct7_i(funct7),
    .RS1_i(rs1), .RS2_i(rs2), .ex_mem_read_i(ex_mem_read), .ex_rd_i(ex_rd),
    .flush_i(flush), .ALUOp_o(alu_op), .ALUSrc_o(alu_src), .RegWrite_o(reg_write),
    .MemRead_o(mem_read), .MemWrite_o(mem_write), .MemtoReg_o(mem_to_reg),
    .Branch_o(branch), .Mul_o(mul), .valid_o(valid_out), .stall_o(stall),
    .illegal_o(illegal)
  );

  // {aluop[1:0], alusrc, regwrite, memread, memwrite, memtoreg, branch, mul, valid, illegal}
  typedef logic [10:0] bundle_t;
  bundle_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int m_wait   = 0;
  bit m_ill    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_supported(input logic [6:0] o);
    return (o == R) || (o == IA) || (o == LD) || (o == ST) || (o == BR);
  endfunction

  function automatic bundle_t model_decode(input logic [6:0] o, input logic [6:0] f7);
    bit [5:0] t; // regwrite, alusrc, memread, memwrite, memtoreg, branch
    case (o)
      R:       t = 6'b100000;
      IA:      t = 6'b110000;
      LD:      t = 6'b111010;
      ST:      t = 6'b010100;
      BR:      t = 6'b000001;
      default: t = 6'b000000;
    endcase
    return {o[6:5], t[4], t[5], t[3], t[2], t[1], t[0],
            (o == R && f7 == 7'b0000001), 1'b1, 1'b0};
  endfunction

  task automatic step(input logic rn, input logic v, input logic [6:0] o, input logic [6:0] f7,
                      input logic [4:0] a, input logic [4:0] b, input logic emr,
                      input logic [4:0] erd, input logic fl, input string tag);
    bundle_t nb, got;
    bit sup, u2, hz, st;
    @(negedge clk);
    rst_n = rn; valid = v; op = o; funct7 = f7; rs1 = a; rs2 = b;
    ex_mem_read = emr; ex_rd = erd; flush = fl;
    #1;
    sup = model_supported(o);
    u2  = (o == R) || (o == ST) || (o == BR);
    hz  = v && emr && (erd != 0) && ((erd == a) || (u2 && erd == b));
    nb  = '0;
    if (!rn) begin
      st = 1'b0; m_wait = 0; m_ill = 1'b0;
    end else if (m_wait > 0) begin
      st = !fl;
      m_wait = fl ? 0 : m_wait - 1;
    end else begin
      st = hz && !fl;
      if (v && !fl && !hz && sup && !m_ill) begin
        nb = model_decode(o, f7);
        if (nb[2] && MUL_LAT > 1) m_wait = MUL_LAT - 1;
      end
    end
`ifdef CTRL_ILLEGAL_TRAP_EN
    if (rn && v && !fl && !st && !sup) m_ill = 1'b1;
`endif
    nb[0] = m_ill;
    check({tag, "/stall"}, 32'(stall), 32'(st));
    exp_q.push_back(nb);
    @(posedge clk);
    #1;
    got = {alu_op, alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch, mul,
           valid_out, illegal};
    check({tag, "/bundle"}, 32'(got), 32'(exp_q.pop_front()));
  endtask

  initial begin
    logic [6:0] ops [7];
    ops[0] = R; ops[1] = IA; ops[2] = LD; ops[3] = ST; ops[4] = BR; ops[5] = 7'h37; ops[6] = XX;
    rst_n = 1'b0; valid = 1'b0; op = '0; funct7 = '0; rs1 = '0; rs2 = '0;
    ex_mem_read = 1'b0; ex_rd = '0; flush = 1'b0;

    step(0, 0, 0,  0, 0, 0, 0, 0, 0, "rst0");
    step(0, 1, R,  0, 1, 2, 0, 0, 0, "rst1");
    step(1, 1, R,  0, 1, 2, 0, 0, 0, "rtype");
    step(1, 1, LD, 0, 1, 2, 0, 0, 0, "load");
    step(1, 1, IA, 0, 1, 2, 0, 0, 0, "ialu");
    step(1, 1, ST, 0, 1, 2, 0, 0, 0, "store");
    step(1, 1, BR, 0, 1, 2, 0, 0, 0, "branch");
    step(1, 1, R,  0, 3, 5, 1, 5, 0, "hz_rs2");
    step(1, 1, R,  0, 3, 5, 1, 0, 0, "hz_x0");
    step(1, 1, IA, 0, 3, 5, 1, 5, 0, "ialu_rs2");
    step(1, 1, LD, 0, 5, 1, 1, 5, 0, "hz_rs1");
    step(1, 1, ST, 0, 2, 7, 1, 7, 0, "hz_st");
    step(1, 1, R,  0, 5, 5, 1, 5, 1, "flush_hz");
    step(1, 0, R,  0, 1, 2, 0, 0, 0, "novalid");
    step(1, 1, R,  1, 1, 2, 0, 0, 0, "mul");
    step(1, 1, IA, 0, 1, 2, 0, 0, 0, "mul_w1");
    step(1, 1, IA, 0, 1, 2, 0, 0, 0, "mul_w2");
    step(1, 1, IA, 0, 1, 2, 0, 0, 0, "mul_done");
    step(1, 1, R,  1, 1, 2, 0, 0, 0, "mul2");
    step(1, 1, LD, 0, 1, 2, 0, 0, 1, "mul_flush");
    step(1, 1, LD, 0, 1, 2, 0, 0, 0, "after_flush");
    step(1, 1, R,  1, 1, 2, 0, 0, 0, "mul3");
    step(0, 1, R,  0, 1, 2, 0, 0, 0, "rst_mulwait");
    step(1, 1, BR, 0, 1, 2, 0, 0, 0, "after_rst");
    step(1, 1, XX, 0, 1, 2, 0, 0, 0, "illop");
    step(1, 1, R,  0, 1, 2, 0, 0, 0, "post_ill");
    step(1, 1, LD, 0, 1, 2, 0, 0, 0, "post_ill2");
    step(0, 0, 0,  0, 0, 0, 0, 0, 0, "rst_ill");
    step(1, 1, R,  0, 1, 2, 0, 0, 0, "after_ill");

    for (int i = 0; i < 400; i++) begin
      logic [6:0] o;
      o = ops[$urandom_range(0, 5) + (($urandom_range(0, 19) == 0) ? 1 : 0)];
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 5) != 0), o,
           7'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
